// File: rtl/trace_capture.sv
// Instruction trace capture: classifies each captured cycle into a record
// and queues it in a DEPTH-entry FIFO; a halt record ends capture and drains.
module trace_capture #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cap_en,
  input  logic [15:0]                pc,
  input  logic                       reg_write,
  input  logic [3:0]                 write_reg,
  input  logic [15:0]                write_data,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [15:0]                mem_addr,
  input  logic [15:0]                mem_data,
  input  logic                       hlt,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [2:0]                 rec_type,
  output logic [3:0]                 rec_reg,
  output logic [63:0]                rec_data,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       done
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  localparam logic [2:0] T_REG = 3'd0, T_LD = 3'd1, T_ST = 3'd2,
                         T_NOP = 3'd3, T_HALT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_HALT_PEND, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]    type_mem [DEPTH];
  logic [3:0]    reg_mem  [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   inum;
  logic [63:0]   pend_data;

  logic [2:0]  cur_type;
  logic [3:0]  cur_reg;
  logic [15:0] fa, fb;

  logic cap, pend_st, push_req, push, pop, can_push, drop, pend_load;
  logic [2:0]  in_type;
  logic [3:0]  in_reg;
  logic [63:0] in_data;

  assign pop      = rec_valid & rec_ready;
  assign can_push = (level < FULL) || pop;

  // Record classification, reg_write has priority over hlt
  always_comb begin
    cur_type = T_NOP;
    cur_reg  = 4'd0;
    fa       = 16'd0;
    fb       = 16'd0;
    if (reg_write && mem_read) begin
      cur_type = T_LD;  cur_reg = write_reg; fa = write_data; fb = mem_addr;
    end else if (reg_write) begin
      cur_type = T_REG; cur_reg = write_reg; fa = write_data;
    end else if (hlt) begin
      cur_type = T_HALT;
    end else if (mem_write) begin
      cur_type = T_ST;  fa = mem_addr; fb = mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cap_en) state_nxt = S_CAPTURE;
      S_CAPTURE:
        if (!cap_en)                state_nxt = S_IDLE;
        else if (cur_type == T_HALT) state_nxt = can_push ? S_DRAIN : S_HALT_PEND;
      S_HALT_PEND: if (can_push) state_nxt = S_DRAIN;
      S_DRAIN:     if (level == '0) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_DONE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cap       = (state == S_CAPTURE) && cap_en;
    pend_st   = (state == S_HALT_PEND);
    push_req  = cap || pend_st;
    push      = push_req && can_push;
    drop      = cap && !can_push && (cur_type != T_HALT);
    pend_load = cap && !can_push && (cur_type == T_HALT);
    in_type   = pend_st ? T_HALT : cur_type;
    in_reg    = pend_st ? 4'd0 : cur_reg;
    in_data   = pend_st ? pend_data : {inum, pc, fa, fb};
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      type_mem[wr_ptr] <= in_type;
      reg_mem[wr_ptr]  <= in_reg;
      data_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      inum      <= 16'd0;
      overflow  <= 1'b0;
      drop_cnt  <= 8'd0;
      pend_data <= 64'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (cap) inum <= inum + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (pend_load) pend_data <= {inum, pc, 32'd0};
    end
  end

  // Head is gated so an empty FIFO never shows stale storage
  assign rec_valid = (level != '0);
  assign rec_type  = rec_valid ? type_mem[rd_ptr] : 3'd0;
  assign rec_reg   = rec_valid ? reg_mem[rd_ptr]  : 4'd0;
  assign rec_data  = rec_valid ? data_mem[rd_ptr] : 64'd0;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture: hand-computed records per scenario.
module tb_trace_capture;
  localparam int DEPTH = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic cap_en, reg_write, mem_read, mem_write, hlt, rec_ready;
  logic [15:0] pc, write_data, mem_addr, mem_data;
  logic [3:0]  write_reg;
  logic rec_valid, overflow, done;
  logic [2:0]  rec_type;
  logic [3:0]  rec_reg;
  logic [63:0] rec_data;
  logic [7:0]  drop_cnt;
  logic [$clog2(DEPTH):0] level;

  int errors = 0, checks = 0;

  trace_capture #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .pc(pc), .reg_write(reg_write),
    .write_reg(write_reg), .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .hlt(hlt),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_type(rec_type),
    .rec_reg(rec_reg), .rec_data(rec_data), .overflow(overflow),
    .drop_cnt(drop_cnt), .level(level), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr_in();
    cap_en = 0; reg_write = 0; mem_read = 0; mem_write = 0; hlt = 0;
    rec_ready = 0; pc = 0; write_data = 0; mem_addr = 0; mem_data = 0; write_reg = 0;
  endtask

  task automatic do_reset();
    clr_in();
    rst = 1; step(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rec_valid !== 0 || level !== 0 || overflow !== 0 || drop_cnt !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_state: valid=%0b level=%0d ovf=%0b drop=%0d done=%0b, need all 0",
               rec_valid, level, overflow, drop_cnt, done);
    end
    checks++;
    if (rec_type !== 0 || rec_reg !== 0 || rec_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_head: type=%0d reg=%0d data=%h, need 0", rec_type, rec_reg, rec_data);
    end
  endtask

  task automatic test_reg_record();
    do_reset();
    cap_en = 1; rec_ready = 1; step();
    reg_write = 1; write_reg = 3; write_data = 16'h00AB; pc = 16'h0002; step();
    checks++;
    if (rec_valid !== 1 || rec_type !== 3'd0 || rec_reg !== 4'd3 ||
        rec_data !== 64'h0000_0002_00AB_0000) begin
      errors++;
      $display("FAIL reg_record: valid=%0b type=%0d reg=%0d data=%h, need 1/0/3/0000000200ab0000",
               rec_valid, rec_type, rec_reg, rec_data);
    end
    clr_in(); rec_ready = 1; step();
    checks++;
    if (level !== 0) begin
      errors++; $display("FAIL reg_pop: level=%0d need 0", level);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cap_en = 1; step();
    mem_write = 1; mem_addr = 16'h0010; mem_data = 16'h1234; pc = 16'h0040;
    repeat (DEPTH + 3) step();
    checks++;
    if (level !== DEPTH || overflow !== 1 || drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL overflow: level=%0d ovf=%0b drop=%0d, need %0d/1/3", level, overflow, drop_cnt, DEPTH);
    end
    clr_in(); step();
    rec_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (rec_valid !== 1 || rec_type !== 3'd2 ||
          rec_data !== {16'(i), 16'h0040, 16'h0010, 16'h1234}) begin
        errors++;
        $display("FAIL ovf_drain[%0d]: valid=%0b type=%0d data=%h, need 1/2/%h", i, rec_valid,
                 rec_type, rec_data, {16'(i), 16'h0040, 16'h0010, 16'h1234});
      end
      step();
    end
    checks++;
    if (rec_valid !== 0 || overflow !== 1) begin
      errors++; $display("FAIL ovf_empty: valid=%0b ovf=%0b, need 0/1", rec_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cap_en = 1; step();
    repeat (DEPTH) step();
    rec_ready = 1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rec_type !== 3'd3 || rec_data[63:48] !== 16'(k)) begin
        errors++;
        $display("FAIL b2b_head[%0d]: type=%0d inum=%0d, need 3/%0d", k, rec_type, rec_data[63:48], k);
      end
      step();
      checks++;
      if (level !== DEPTH || drop_cnt !== 0 || overflow !== 0) begin
        errors++;
        $display("FAIL b2b_level[%0d]: level=%0d drop=%0d ovf=%0b, need %0d/0/0", k, level, drop_cnt, overflow, DEPTH);
      end
    end
  endtask

  task automatic test_halt_pend();
    do_reset();
    cap_en = 1; step();
    repeat (DEPTH) step();
    hlt = 1; step();
    hlt = 0; cap_en = 0; step();
    checks++;
    if (level !== DEPTH || drop_cnt !== 0 || done !== 0) begin
      errors++;
      $display("FAIL halt_pend_hold: level=%0d drop=%0d done=%0b, need %0d/0/0", level, drop_cnt, done, DEPTH);
    end
    rec_ready = 1; step(); rec_ready = 0;
    checks++;
    if (level !== DEPTH || rec_data[63:48] !== 16'd1) begin
      errors++;
      $display("FAIL halt_enq: level=%0d head_inum=%0d, need %0d/1", level, rec_data[63:48], DEPTH);
    end
    cap_en = 1; rec_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++;
        if (rec_type !== 3'd4 || rec_reg !== 0 || rec_data[63:48] !== 16'(DEPTH) || rec_data[31:0] !== 0) begin
          errors++;
          $display("FAIL halt_last: type=%0d reg=%0d data=%h, need type4 inum %0d", rec_type, rec_reg, rec_data, DEPTH);
        end
      end
      step();
    end
    checks++;
    if (level !== 0 || done !== 0) begin
      errors++; $display("FAIL halt_drained: level=%0d done=%0b, need 0/0", level, done);
    end
    step();
    checks++;
    if (done !== 1) begin
      errors++; $display("FAIL halt_done: done=%0b need 1", done);
    end
    reg_write = 1; step(); step();
    checks++;
    if (level !== 0 || done !== 1) begin
      errors++; $display("FAIL done_ignore: level=%0d done=%0b, need 0/1", level, done);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cap_en = 1; step();
    reg_write = 1; hlt = 1; write_reg = 5; write_data = 16'h1111; pc = 16'h0010; step();
    hlt = 0; mem_read = 1; write_reg = 7; write_data = 16'h2222; mem_addr = 16'h3333; pc = 16'h0012; step();
    clr_in(); step();
    checks++;
    if (level !== 2 || rec_type !== 3'd0 || rec_reg !== 4'd5 ||
        rec_data !== 64'h0000_0010_1111_0000) begin
      errors++;
      $display("FAIL prio_reg: level=%0d type=%0d reg=%0d data=%h, need 2/0/5/0000001011110000",
               level, rec_type, rec_reg, rec_data);
    end
    rec_ready = 1; step(); rec_ready = 0;
    checks++;
    if (rec_type !== 3'd1 || rec_reg !== 4'd7 || rec_data !== 64'h0001_0012_2222_3333) begin
      errors++;
      $display("FAIL prio_ld: type=%0d reg=%0d data=%h, need 1/7/0001001222223333", rec_type, rec_reg, rec_data);
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    cap_en = 1; step();
    repeat (4) step();
    hlt = 1; step();
    hlt = 0; step();
    checks++;
    if (level !== 5 || done !== 0) begin
      errors++; $display("FAIL drain_hold: level=%0d done=%0b, need 5/0", level, done);
    end
    #2 rst = 1; #1;
    checks++;
    if (level !== 0 || rec_valid !== 0 || done !== 0 || rec_data !== 0) begin
      errors++;
      $display("FAIL async_rst: level=%0d valid=%0b done=%0b data=%h, need 0", level, rec_valid, done, rec_data);
    end
    @(negedge clk); rst = 0; clr_in();
    cap_en = 1; step();
    reg_write = 1; write_reg = 2; write_data = 16'h0055; pc = 16'h0100; step();
    clr_in(); step();
    checks++;
    if (level !== 1 || rec_data !== 64'h0000_0100_0055_0000) begin
      errors++;
      $display("FAIL post_rst_inum: level=%0d data=%h, need 1/0000010000550000", level, rec_data);
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    cap_en = 1; step();
    repeat (DEPTH + 260) step();
    checks++;
    if (drop_cnt !== 8'hFF || overflow !== 1 || level !== DEPTH) begin
      errors++;
      $display("FAIL drop_sat: drop=%0d ovf=%0b level=%0d, need 255/1/%0d", drop_cnt, overflow, level, DEPTH);
    end
  endtask

  initial begin
    clr_in();
    test_reset();
    test_reg_record();
    test_overflow();
    test_back_to_back();
    test_halt_pend();
    test_priority();
    test_reset_in_drain();
    test_drop_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/trace_capture.md
TRACE_CAPTURE -- requirements
Module: trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the FIFO record count; must be a power of 2, minimum 2.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-high reset
  cap_en  in  1  capture enable
  pc  in  16  PC of the instruction in the current cycle
  reg_write  in  1  register file write this cycle
  write_reg  in  4  destination register
  write_data  in  16  register write data
  mem_read  in  1  memory read this cycle
  mem_write  in  1  memory write this cycle
  mem_addr  in  16  memory address
  mem_data  in  16  memory store data
  hlt  in  1  halt executing
  rec_valid  out  1  head record available
  rec_ready  in  1  reader accepts head record
  rec_type  out  3  head record type
  rec_reg  out  4  head record register
  rec_data  out  64  head record {inum[15:0], pc[15:0], fieldA[15:0], fieldB[15:0]}
  overflow  out  1  sticky flag: a record was dropped
  drop_cnt  out  8  dropped-record count
  level  out  $clog2(DEPTH)+1  FIFO occupancy
  done  out  1  halt record drained

Function
REQ-003 SHALL classify each CAPTURE cycle with this priority: reg_write&mem_read -> LD(1); reg_write -> REG(0); hlt -> HALT(4); mem_write -> ST(2); otherwise NOP(3).
REQ-004 SHALL fill fields as follows: REG A=write_data, B=0; LD A=write_data, B=mem_addr; ST A=mem_addr, B=mem_data; NOP and HALT A=B=0; rec_reg=write_reg for REG/LD, else 0.
REQ-005 SHALL stamp each generated record with inum from a 16-bit counter that starts at 0, increments once per generated record (dropped records included), and wraps 0xFFFF->0.
REQ-006 SHALL implement FSM states IDLE, CAPTURE, HALT_PEND, DRAIN, DONE.
REQ-007 IDLE: no records; cap_en=1 -> CAPTURE; the first record is generated in the following cycle.
REQ-008 CAPTURE: one record per cycle; cap_en=0 -> IDLE with no record that cycle; inum is held.
REQ-009 CAPTURE with a HALT record: enqueue if space -> DRAIN; if full -> latch the record in a pending register and go to HALT_PEND.
REQ-010 HALT_PEND: no new records; enqueue the pending HALT as soon as space exists -> DRAIN; a HALT record is never dropped.
REQ-011 DRAIN: ignores all inputs; level==0 -> DONE.
REQ-012 DONE: done=1 and all inputs ignored until rst.
REQ-013 A push SHALL be accepted when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
REQ-014 A non-HALT record that cannot be pushed SHALL be dropped, overflow SHALL set (sticky), and drop_cnt SHALL increment, saturating at 255.
REQ-015 A pop SHALL occur when rec_valid&rec_ready; rec_valid=(level!=0); outputs come from registered FIFO storage with zero-cycle head visibility.
REQ-016 A record pushed at edge N SHALL be visible with rec_valid=1 after edge N, when the FIFO was empty.
REQ-017 Pointers SHALL wrap modulo DEPTH; level SHALL go up only on push-only, down only on pop-only, and be unchanged on push+pop.
REQ-018 Records SHALL be delivered in generation order with none duplicated.

Reset
REQ-019 rst SHALL asynchronously force state IDLE, the FIFO empty, level=0, rec_valid=0, inum=0, overflow=0, drop_cnt=0, done=0, and the pending register cleared.
REQ-020 rst mid-operation (any state, FIFO non-empty) SHALL discard all records; the first post-reset record SHALL carry inum=0.
REQ-021 rec_type, rec_reg and rec_data SHALL read 0 while level=0 after reset.

Verification
REQ-022 cap_en=1, rec_ready=1, cycle1 reg_write=1, write_reg=3, write_data=0x00AB, pc=0x0002 -> record type0, reg3, data 0x0000_0002_00AB_0000.
REQ-023 rec_ready=0, mem_write=1, mem_addr=0x0010, mem_data=0x1234 for DEPTH+3 cycles -> level=DEPTH, overflow=1, drop_cnt=3; drained records carry inum 0..DEPTH-1.
REQ-024 FIFO full, rec_ready=0, hlt=1 -> HALT_PEND; pulse rec_ready once -> HALT enqueued; drain everything -> the last record is type4 and done=1 one cycle after level=0.
REQ-025 Full FIFO with rec_ready=1 and a NOP every cycle -> level stays at DEPTH, no drops, inum increases by 1 per record.
REQ-026 Same-cycle reg_write=1 and hlt=1 -> REG record, FSM stays in CAPTURE; same-cycle reg_write=1 and mem_read=1 -> LD record with B=mem_addr.
REQ-027 Assert rst in DRAIN with level=5 -> level=0, done=0, IDLE immediately; next record inum=0.
